eth_rx_fcs_checker: RTL
=======================

Name: eth_rx_fcs_checker

Overview:
Consumes the Ethernet MAC's receive byte stream (rx_valid/rx_ready/rx_data/rx_last) and checks each frame's CRC-32 FCS and length. It forwards the frame with its trailing 4 FCS bytes removed on a payload stream with the same valid/ready/last protocol. It reports one status record per frame. It sits directly downstream of the MAC receive channel and drives that channel's rx_ready.

Parameters:
MIN_FRAME, 64, minimum legal frame length in bytes, FCS included; shorter frames are flagged runt.
MAX_FRAME, 1518, maximum legal frame length in bytes, FCS included; longer frames are flagged giant.

Ports:
ETH_CLK  input  1  block clock; all logic rising-edge.
ETH_RST  input  1  synchronous reset, active-high.
rx_valid  input  1  input byte valid.
rx_ready  output  1  block can accept an input byte.
rx_data  input  8  input byte.
rx_last  input  1  input byte is the final frame byte (last FCS byte).
pl_valid  output  1  payload byte valid (registered).
pl_ready  input  1  downstream accepts payload byte.
pl_data  output  8  payload byte (registered).
pl_last  output  1  final payload byte of frame (registered).
stat_valid  output  1  one-cycle pulse: status for a completed frame.
stat_len  output  16  total frame bytes incl. FCS, saturating at 0xFFFF.
stat_crc_ok  output  1  FCS correct.
stat_runt  output  1  stat_len < MIN_FRAME.
stat_giant  output  1  stat_len > MAX_FRAME.

Behaviour:
- Reset:
  - pl_valid, pl_data, pl_last, stat_valid and all stat_* outputs = 0.
  - Delay-buffer fill = 0, length = 0, CRC register = 0xFFFFFFFF.
  - rx_ready = 1 in the first cycle after reset.
- Accept:
  - A byte is accepted when rx_valid && rx_ready.
  - rx_ready = (fill < 4) || !pl_valid || pl_ready. This is combinational from pl_ready.
- Delay buffer:
  - 4-byte FIFO shift register, oldest first.
  - On accept with fill < 4: push the byte, fill++.
  - On accept with fill == 4: oldest byte moves to pl_data, pl_valid = 1, pl_last = rx_last; the new byte is pushed.
  - Each payload byte appears on pl_data the cycle after byte N+4 is accepted.
- Output register: pl_valid clears on pl_valid && pl_ready unless it is reloaded in the same cycle. pl_data and pl_last are held stable while pl_valid && !pl_ready.
- Frame end (accept with rx_last = 1):
  - The buffered 4 bytes are the FCS and are discarded.
  - Next cycle: fill = 0, length = 0, CRC = 0xFFFFFFFF, ready for the next frame's first byte.
- Short frames (len ≤ 4): no payload bytes are emitted and pl_last never fires; status is still produced.
- CRC:
  - IEEE 802.3, reflected polynomial 0xEDB88320, init 0xFFFFFFFF, one byte per accept, LSB first.
  - Computed over all bytes including the FCS.
  - stat_crc_ok = 1 iff the register after the last byte equals residue 0xDEBB20E3.
  - Combinational byte-wide update, no pipelining.
- Length: 16-bit count of accepted bytes in the frame, including the rx_last byte; saturates at 0xFFFF.
- Status:
  - stat_valid pulses exactly one cycle, the cycle after the rx_last byte is accepted.
  - stat_* outputs are valid during that pulse and hold their value until the next pulse.
  - Status has no backpressure. It may precede pl_last being accepted downstream.
- Back-to-back frames: the first byte of frame k+1 may be accepted the cycle after frame k's rx_last. The status pulse for frame k and that accept may coincide.
- Reset mid-frame:
  - The partial frame is dropped with no status pulse.
  - Any pending pl byte is discarded (pl_valid = 0).
- Robustness: rx_valid low between bytes is allowed anywhere in a frame and leaves all state unchanged.

Test Plan:
1. 13-byte frame "123456789" + FCS 26 39 F4 CB, pl_ready = 1 -> 9 payload bytes 0x31..0x39, pl_last on 0x39; stat_len = 13, crc_ok = 1, runt = 1, giant = 0.
2. 64-byte frame (60 random payload bytes + correct FCS) -> 60 payload bytes in order, pl_last on byte 60; stat_len = 64, crc_ok = 1, runt = 0. Same frame with bit 0 of byte 10 flipped -> crc_ok = 0, payload reflects the flip.
3. 3-byte frame AA BB CC with rx_last on CC -> pl_valid never asserts; stat_valid one pulse, stat_len = 3, runt = 1, crc_ok = 0.
4. 64-byte frame with pl_ready = 1,0,0,1 repeating and random rx_valid gaps -> byte-exact 60-byte payload with no drops or duplicates; pl_data stable while stalled; rx_ready = 0 whenever fill = 4, pl_valid = 1, pl_ready = 0.
5. 1519-byte correct-FCS frame followed immediately (next cycle) by the 64-byte frame -> first status len = 1519, giant = 1, crc_ok = 1; second status len = 64, giant = 0; payload counts 1515 and 60.
6. Assert ETH_RST after 20 bytes of a frame, then send the test-1 frame -> all outputs 0 the cycle after reset; no status for the aborted frame; test-1 results reproduced exactly.

Source files
------------

// File: rtl/eth_rx_fcs_checker.sv
// Ethernet receive FCS checker: strips the trailing 4-byte FCS through a 4-byte delay
// buffer, verifies CRC-32 and frame length, and reports one status record per frame.
module eth_rx_fcs_checker #(
    parameter int MIN_FRAME = 64,
    parameter int MAX_FRAME = 1518
) (
    input  logic        ETH_CLK,
    input  logic        ETH_RST,
    input  logic        rx_valid,
    output logic        rx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_last,
    output logic        pl_valid,
    input  logic        pl_ready,
    output logic [7:0]  pl_data,
    output logic        pl_last,
    output logic        stat_valid,
    output logic [15:0] stat_len,
    output logic        stat_crc_ok,
    output logic        stat_runt,
    output logic        stat_giant
);

    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [3:0][7:0] buf_q, buf_d;
    logic [2:0]      fill_q, fill_d;
    logic [15:0]     len_q, len_d;
    logic [31:0]     crc_q, crc_d;
    logic            pl_valid_q, pl_valid_d;
    logic [7:0]      pl_data_q, pl_data_d;
    logic            pl_last_q, pl_last_d;
    logic            stat_valid_q, stat_valid_d;
    logic [15:0]     stat_len_q, stat_len_d;
    logic            stat_crc_ok_q, stat_crc_ok_d;
    logic            stat_runt_q, stat_runt_d;
    logic            stat_giant_q, stat_giant_d;

    logic            accept;
    logic [31:0]     crc_next;
    logic [15:0]     len_next;

    always_comb begin
        rx_ready      = (fill_q < 3'd4) || !pl_valid_q || pl_ready;
        accept        = rx_valid && rx_ready;
        crc_next      = crc32_byte(crc_q, rx_data);
        len_next      = sat_inc(len_q);

        buf_d         = buf_q;
        fill_d        = fill_q;
        len_d         = len_q;
        crc_d         = crc_q;
        pl_valid_d    = pl_valid_q && !pl_ready;
        pl_data_d     = pl_data_q;
        pl_last_d     = pl_last_q;
        stat_valid_d  = 1'b0;
        stat_len_d    = stat_len_q;
        stat_crc_ok_d = stat_crc_ok_q;
        stat_runt_d   = stat_runt_q;
        stat_giant_d  = stat_giant_q;

        if (accept) begin
            crc_d = crc_next;
            len_d = len_next;
            if (fill_q == 3'd4) begin
                // Buffer full: the oldest byte is known not to be FCS, release it.
                pl_valid_d = 1'b1;
                pl_data_d  = buf_q[0];
                pl_last_d  = rx_last;
                buf_d      = {rx_data, buf_q[3], buf_q[2], buf_q[1]};
            end else begin
                buf_d[fill_q[1:0]] = rx_data;
                fill_d             = fill_q + 3'd1;
            end
            if (rx_last) begin
                fill_d        = 3'd0;
                len_d         = 16'd0;
                crc_d         = CRC_INIT;
                stat_valid_d  = 1'b1;
                stat_len_d    = len_next;
                stat_crc_ok_d = (crc_next == CRC_RESIDUE);
                stat_runt_d   = int'(len_next) < MIN_FRAME;
                stat_giant_d  = int'(len_next) > MAX_FRAME;
            end
        end
    end

    always_ff @(posedge ETH_CLK) begin
        if (ETH_RST) begin
            fill_q        <= 3'd0;
            len_q         <= 16'd0;
            crc_q         <= CRC_INIT;
            pl_valid_q    <= 1'b0;
            pl_data_q     <= 8'd0;
            pl_last_q     <= 1'b0;
            stat_valid_q  <= 1'b0;
            stat_len_q    <= 16'd0;
            stat_crc_ok_q <= 1'b0;
            stat_runt_q   <= 1'b0;
            stat_giant_q  <= 1'b0;
        end else begin
            fill_q        <= fill_d;
            len_q         <= len_d;
            crc_q         <= crc_d;
            pl_valid_q    <= pl_valid_d;
            pl_data_q     <= pl_data_d;
            pl_last_q     <= pl_last_d;
            stat_valid_q  <= stat_valid_d;
            stat_len_q    <= stat_len_d;
            stat_crc_ok_q <= stat_crc_ok_d;
            stat_runt_q   <= stat_runt_d;
            stat_giant_q  <= stat_giant_d;
        end
    end

    // Buffer contents are qualified by fill_q, so they need no reset.
    always_ff @(posedge ETH_CLK) begin
        buf_q <= buf_d;
    end

    assign pl_valid    = pl_valid_q;
    assign pl_data     = pl_data_q;
    assign pl_last     = pl_last_q;
    assign stat_valid  = stat_valid_q;
    assign stat_len    = stat_len_q;
    assign stat_crc_ok = stat_crc_ok_q;
    assign stat_runt   = stat_runt_q;
    assign stat_giant  = stat_giant_q;

endmodule
